// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave bridging one address slot onto NUM_SLV APB peripherals.
// Two-cycle AHB ERROR on decode, size, PSLVERR or ACCESS timeout faults.
module ahb_apb_bridge_mc #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic                      HREADY,
  input  logic [DATA_W-1:0]         HWDATA,
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADYOUT,
  output logic [1:0]                HRESP,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      err_clr,
  output logic [2:0]                err_status
);

  localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [2:0]     MAX_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [IDX_W:0] SLV_LIM  = (IDX_W + 1)'(NUM_SLV);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERR1   = 3'd4;
  localparam logic [2:0] ERR2   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SLV_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        err_q, err_d;
  logic [2:0]        err_ev;

  logic [IDX_W-1:0]   haddr_idx;
  logic               idx_bad;
  logic               size_bad;
  logic               can_accept;
  logic               accept;
  logic               apb_act;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic [NUM_SLV-1:0] sel_onehot;
  logic               unused_ok;

  assign haddr_idx  = (NUM_SLV > 1) ? HADDR[SLV_AW +: IDX_W] : '0;
  assign idx_bad    = {1'b0, haddr_idx} >= SLV_LIM;
  assign size_bad   = HSIZE > MAX_SIZE;
  assign can_accept = (state_q == IDLE) || (state_q == DONE) ||
                      (state_q == ERR2);
  assign accept     = can_accept & HSEL & HREADY & HTRANS[1];
  assign unused_ok  = ^{HTRANS[0], HADDR};

  // Only the addressed slave's response is ever looked at.
  always_comb begin
    sel_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_ready     = PREADY[i];
        sel_err       = PSLVERR[i];
        sel_rdata     = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    write_d  = write_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    err_ev   = 3'b000;
    unique case (state_q)
      IDLE, DONE, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          idx_d   = haddr_idx;
          addr_d  = HADDR[SLV_AW-1:0];
          write_d = HWRITE;
          if (idx_bad || size_bad) begin
            state_d   = ERR1;
            err_ev[0] = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
        if (write_q) pwdata_d = HWDATA;
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A late PREADY on the final allowed cycle still completes.
        if (sel_ready) begin
          if (sel_err) begin
            state_d   = ERR1;
            err_ev[1] = 1'b1;
          end else begin
            state_d = DONE;
            if (!write_q) hrdata_d = sel_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          state_d   = ERR1;
          err_ev[2] = 1'b1;
        end
      end
      ERR1: state_d = ERR2;
      default: state_d = IDLE;
    endcase
    err_d = (err_clr ? 3'b000 : err_q) | err_ev;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
      err_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign apb_act    = (state_q == SETUP) || (state_q == ACCESS);
  assign PSEL       = apb_act ? sel_onehot : '0;
  assign PENABLE    = state_q == ACCESS;
  assign PWRITE     = write_q;
  assign PADDR      = ADDR_W'(addr_q);
  // SETUP forwards the live data-phase word; ACCESS replays the captured copy.
  assign PWDATA     = ((state_q == SETUP) && write_q) ? HWDATA : pwdata_q;
  assign HREADYOUT  = can_accept;
  assign HRESP      = ((state_q == ERR1) || (state_q == ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA     = hrdata_q;
  assign err_status = err_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Scoreboard bench for ahb_apb_bridge_mc with three APB slave models.
// Driver queues expected responses; a negedge monitor pops and checks.
module tb_ahb_apb_bridge_mc;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int SAW = 12;
  localparam int TO  = 4;

  logic          HCLK;
  logic          HRESETn;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADYOUT;
  logic [1:0]    HRESP;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PENABLE;
  logic [NS-1:0] PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0] PREADY;
  logic [NS-1:0] PSLVERR;
  logic          err_clr;
  logic [2:0]    err_status;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_apb_bridge_mc #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SLV_AW(SAW), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .err_clr(err_clr), .err_status(err_status)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    logic [2:0]  psel;
    logic [11:0] paddr;
    logic        wr;
    logic [31:0] wdata;
    logic [2:0]  err;
    int          issue;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          waits [NS];
  logic        serr  [NS];
  logic        stuck [NS];
  logic        noise [NS];
  logic [31:0] sdata [NS];
  int          wcnt  [NS];

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK)
    for (int i = 0; i < NS; i++)
      wcnt[i] <= (PSEL[i] && PENABLE) ? wcnt[i] + 1 : 0;

  always_comb begin
    PREADY  = '0;
    PSLVERR = '0;
    PRDATA  = '0;
    for (int i = 0; i < NS; i++) begin
      PREADY[i]  = noise[i] |
                   (PSEL[i] & PENABLE & ~stuck[i] & (wcnt[i] >= waits[i]));
      PSLVERR[i] = noise[i] | (PSEL[i] & serr[i]);
      PRDATA[i*DW +: DW] = sdata[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] resp, input logic [31:0] rd,
                              input int lat, input logic [2:0] ps,
                              input logic [11:0] pa, input logic wr,
                              input logic [31:0] wd, input logic [2:0] er);
    exp_t e;
    e.resp = resp; e.rdata = rd; e.lat = lat; e.psel = ps;
    e.paddr = pa; e.wr = wr; e.wdata = wd; e.err = er; e.issue = 0;
    return e;
  endfunction

  // Monitor: tracks APB activity and pops one entry per completed transfer.
  bit          low_seen;
  bit          err1_seen;
  logic [2:0]  psel_acc;
  logic [11:0] cap_addr;
  logic        cap_wr;
  logic [31:0] cap_wd;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      low_seen  = 1'b0;
      err1_seen = 1'b0;
      psel_acc  = '0;
    end else begin
      if (PSEL != '0 && !PENABLE) begin
        cap_addr = PADDR[11:0];
        cap_wr   = PWRITE;
        cap_wd   = PWDATA;
      end
      if (PSEL != '0 && PENABLE) begin
        chk("apb_hold_addr", 64'(PADDR), 64'({20'b0, cap_addr}));
        chk("apb_hold_data", 64'({PWRITE, PWDATA}), 64'({cap_wr, cap_wd}));
      end
      psel_acc = psel_acc | PSEL;
      if (!HREADYOUT) begin
        low_seen = 1'b1;
        if (HRESP == 2'b01) err1_seen = 1'b1;
      end else if (low_seen) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          mon_e = sb_q.pop_front();
          chk("hresp", 64'({err1_seen, HRESP}),
              64'((mon_e.resp == 2'b01) ? 3'b101 : 3'b000));
          chk("hrdata", 64'(HRDATA), 64'(mon_e.rdata));
          chk("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
          chk("psel", 64'(psel_acc), 64'(mon_e.psel));
          chk("err_status", 64'(err_status), 64'(mon_e.err));
          if (mon_e.psel != '0) begin
            chk("paddr", 64'(cap_addr), 64'(mon_e.paddr));
            chk("pwrite", 64'(cap_wr), 64'(mon_e.wr));
            if (mon_e.wr) chk("pwdata", 64'(cap_wd), 64'(mon_e.wdata));
          end
        end
        low_seen  = 1'b0;
        err1_seen = 1'b0;
        psel_acc  = '0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic wr,
                       input logic [2:0] sz, input logic [1:0] tr,
                       input logic [31:0] wd, input bit push,
                       input exp_t e);
    exp_t x;
    bit ok;
    x  = e;
    ok = 1'b0;
    HSEL = 1'b1; HADDR = a; HWRITE = wr; HSIZE = sz; HTRANS = tr;
    for (int n = 0; n < 40; n++) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_wait", 64'(ok), 64'(1));
    x.issue = cyc;
    if (push && ok) sb_q.push_back(x);
    @(posedge HCLK); #1;
    HWDATA = wd;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge HCLK);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_wait", 64'(ok), 64'(1));
    @(posedge HCLK); #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge HCLK); #1;
    err_clr = 1'b0;
    @(negedge HCLK);
    chk("err_clr", 64'(err_status), 64'(0));
    @(posedge HCLK); #1;
  endtask

  task automatic idle_probe(input string nm, input logic sel,
                            input logic [1:0] tr);
    HSEL = sel; HADDR = 32'h0000_1000; HTRANS = tr;
    HWRITE = 1'b0; HSIZE = 3'd2;
    repeat (3) begin
      @(negedge HCLK);
      chk(nm, 64'({PSEL, HREADYOUT, HRESP}), 64'({3'b000, 1'b1, 2'b00}));
    end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    for (int i = 0; i < NS; i++) begin
      waits[i] = 0; serr[i] = 1'b0; stuck[i] = 1'b0; noise[i] = 1'b0;
    end
    sdata[0] = 32'h0000_C0DE;
    sdata[1] = 32'hA5A5_0001;
    sdata[2] = 32'h2222_2222;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = '0; err_clr = 1'b0;

    #12;
    chk("rst_ahb", 64'({HREADYOUT, HRESP, HRDATA}), 64'({1'b1, 2'b00, 32'h0}));
    chk("rst_apb", 64'({PSEL, PENABLE, PWRITE, PADDR}), 64'(0));
    chk("rst_pwdata_err", 64'({PWDATA, err_status}), 64'(0));
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    issue(32'h0000_1004, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1,
          mk(2'b00, 32'hA5A5_0001, 3, 3'b010, 12'h004, 1'b0, 32'h0, 3'b000));
    wait_done();

    waits[2] = 3; noise[0] = 1'b1; noise[1] = 1'b1;
    issue(32'h0000_2010, 1'b1, 3'd2, 2'b10, 32'h55, 1'b1,
          mk(2'b00, 32'hA5A5_0001, 6, 3'b100, 12'h010, 1'b1, 32'h55, 3'b000));
    wait_done();
    noise[0] = 1'b0; noise[1] = 1'b0; waits[2] = 0;

    waits[0] = 1;
    issue(32'hABCD_0FFC, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1,
          mk(2'b00, 32'h0000_C0DE, 4, 3'b001, 12'hFFC, 1'b0, 32'h0, 3'b000));
    wait_done();
    waits[0] = 0;

    serr[0] = 1'b1;
    issue(32'h0000_0020, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1,
          mk(2'b01, 32'h0000_C0DE, 4, 3'b001, 12'h020, 1'b0, 32'h0, 3'b010));
    wait_done();
    serr[0] = 1'b0;
    pulse_clr();

    stuck[1] = 1'b1;
    issue(32'h0000_1008, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1,
          mk(2'b01, 32'h0000_C0DE, 7, 3'b010, 12'h008, 1'b0, 32'h0, 3'b100));
    wait_done();
    stuck[1] = 1'b0;

    err_clr = 1'b1;
    issue(32'h0000_3000, 1'b1, 3'd2, 2'b10, 32'hDEAD, 1'b1,
          mk(2'b01, 32'h0000_C0DE, 2, 3'b000, 12'h000, 1'b1, 32'h0, 3'b001));
    err_clr = 1'b0;
    wait_done();

    issue(32'h0000_1000, 1'b1, 3'd3, 2'b10, 32'h77, 1'b1,
          mk(2'b01, 32'h0000_C0DE, 2, 3'b000, 12'h000, 1'b1, 32'h0, 3'b001));
    wait_done();
    pulse_clr();

    idle_probe("busy_ignored", 1'b1, 2'b01);
    idle_probe("hsel_low_ignored", 1'b0, 2'b10);

    sdata[1] = 32'hBEEF_0002;
    issue(32'h0000_0008, 1'b1, 3'd2, 2'b10, 32'h1234_5678, 1'b1,
          mk(2'b00, 32'h0000_C0DE, 3, 3'b001, 12'h008, 1'b1,
             32'h1234_5678, 3'b000));
    issue(32'h0000_100C, 1'b0, 3'd2, 2'b11, 32'h0, 1'b1,
          mk(2'b00, 32'hBEEF_0002, 3, 3'b010, 12'h00C, 1'b0, 32'h0, 3'b000));
    wait_done();

    stuck[1] = 1'b1;
    issue(32'h0000_1010, 1'b0, 3'd2, 2'b10, 32'h0, 1'b0,
          mk(2'b00, 32'h0, 0, 3'b000, 12'h000, 1'b0, 32'h0, 3'b000));
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge HCLK);
      if (PENABLE) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_access", 64'(ok), 64'(1));
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", 64'(PSEL), 64'(0));
    chk("rst_mid_penable", 64'(PENABLE), 64'(0));
    chk("rst_mid_hready", 64'({HREADYOUT, HRESP}), 64'({1'b1, 2'b00}));
    @(posedge HCLK);
    @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    stuck[1] = 1'b0;
    @(negedge HCLK);
    chk("post_rst_idle", 64'({HREADYOUT, PSEL, PENABLE, err_status}),
        64'({1'b1, 3'b000, 1'b0, 3'b000}));
    chk("post_rst_hrdata", 64'(HRDATA), 64'(0));
    @(posedge HCLK); #1;

    issue(32'h0000_2000, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1,
          mk(2'b00, 32'h2222_2222, 3, 3'b100, 12'h000, 1'b0, 32'h0, 3'b000));
    wait_done();

    repeat (3) @(posedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
